mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter data_size, default 32, the width of the data word.
REQ-002 The block SHALL have parameter mem_size, default 16, the width of the word address.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive DM grants while IM waits.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for MEM_ack.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port IM_Address, input, mem_size bits: the fetch word address.
REQ-008 The block SHALL have port IM_req, input, 1 bit: the fetch request level.
REQ-009 The block SHALL have port Instruction, output, data_size bits: the fetched word.
REQ-010 The block SHALL have port IM_ready, output, 1 bit: a one-cycle fetch-complete pulse.
REQ-011 The block SHALL have port DM_Address, input, mem_size bits: the data word address.
REQ-012 The block SHALL have port DM_req, input, 1 bit: the data access request level.
REQ-013 The block SHALL have port DM_enable, input, 1 bit: 1 selects write, 0 selects read.
REQ-014 The block SHALL have port DM_Write_Data, input, data_size bits: the store data.
REQ-015 The block SHALL have port DM_Read_Data, output, data_size bits: the load data.
REQ-016 The block SHALL have port DM_ready, output, 1 bit: a one-cycle data-complete pulse.
REQ-017 The block SHALL have port MEM_Address, output, mem_size bits: the shared memory address.
REQ-018 The block SHALL have port MEM_req, output, 1 bit: the shared memory request.
REQ-019 The block SHALL have port MEM_we, output, 1 bit: the shared memory write enable.
REQ-020 The block SHALL have port MEM_Write_Data, output, data_size bits: the shared memory write data.
REQ-021 The block SHALL have port MEM_Read_Data, input, data_size bits: the shared memory read data.
REQ-022 The block SHALL have port MEM_ack, input, 1 bit: memory completion, valid only while MEM_req is 1.
REQ-023 The block SHALL have port bus_err, output, 1 bit: sticky timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, BUSY and RESP, with an owner register selecting IM or DM.
REQ-025 In IDLE, on any request, the block SHALL latch owner, address, we (owner DM ? DM_enable : 0) and write data, then enter BUSY; with no request it SHALL stay in IDLE.
REQ-026 With both requests in IDLE, DM SHALL win unless starve_cnt equals STARVE_LIMIT, in which case IM SHALL win.
REQ-027 starve_cnt SHALL increment on a DM grant while IM_req=1, SHALL clear on any IM grant, and SHALL saturate at STARVE_LIMIT.
REQ-028 In BUSY, MEM_req SHALL be 1 and MEM_Address, MEM_we and MEM_Write_Data SHALL come from the latched registers, stable for the whole state.
REQ-029 In BUSY with MEM_ack=1, the block SHALL load MEM_Read_Data into Instruction (owner IM) or into DM_Read_Data (owner DM read only) and enter RESP.
REQ-030 In RESP, the block SHALL pulse the owner's ready output for exactly one cycle, ignore all requests, and return to IDLE.
REQ-031 Requesters SHALL hold req, address and data stable until ready, and drop req on the cycle after ready; the minimum transaction latency is req sampled at T, MEM_req at T+1, ack at T+1, ready at T+2.
REQ-032 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT, bus_err SHALL set, the read target SHALL load 0, and the FSM SHALL enter RESP.
REQ-033 Instruction and DM_Read_Data SHALL hold their values until the next completion on their own port; a DM write SHALL not alter DM_Read_Data.
REQ-034 MEM_ack outside BUSY SHALL be ignored.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and zero all outputs, starve_cnt, the timeout counter and bus_err, and SHALL abandon any in-flight transaction without a ready pulse.
REQ-036 After rst deasserts, the first grant SHALL follow normal priority with starve_cnt=0.

Verification
REQ-037 Single read: IM_req=1, IM_Address=16'h0004, ack on the first BUSY cycle with data 32'h2008000A -> MEM_req for 1 cycle, Instruction=32'h2008000A, IM_ready pulse at T+2.
REQ-038 Simultaneous requests: IM and DM requests in the same cycle -> DM served first, then IM; each ready is a single pulse.
REQ-039 Starvation: DM_req held continuously with IM_req=1 -> after 4 DM grants the 5th grant goes to IM.
REQ-040 Write: DM_enable=1, DM_Address=16'h0010, DM_Write_Data=32'hCAFEF00D -> MEM_we=1 with matching address and data; DM_Read_Data unchanged.
REQ-041 Timeout: no ack for 16 BUSY cycles -> bus_err=1 sticky, ready pulse with data 0.
REQ-042 Reset in BUSY: rst asserted mid-transaction -> MEM_req=0 asynchronously, no ready pulse, bus_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between an instruction fetch port (IM)
// and a data port (DM), with anti-starvation for IM and a bus timeout.
module mem_arbiter #(
    parameter int data_size    = 32,
    parameter int mem_size     = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [mem_size-1:0]  IM_Address,
    input  logic                 IM_req,
    output logic [data_size-1:0] Instruction,
    output logic                 IM_ready,
    input  logic [mem_size-1:0]  DM_Address,
    input  logic                 DM_req,
    input  logic                 DM_enable,
    input  logic [data_size-1:0] DM_Write_Data,
    output logic [data_size-1:0] DM_Read_Data,
    output logic                 DM_ready,
    output logic [mem_size-1:0]  MEM_Address,
    output logic                 MEM_req,
    output logic                 MEM_we,
    output logic [data_size-1:0] MEM_Write_Data,
    input  logic [data_size-1:0] MEM_Read_Data,
    input  logic                 MEM_ack,
    output logic                 bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_IM, OWN_DM} owner_t;

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_dm;
    logic          tmo_last;

    // DM normally wins a tie; IM is forced through once it has been passed over STARVE_LIMIT times.
    always_comb begin
        grant_dm = DM_req && (!IM_req || (starve_cnt != SW'(STARVE_LIMIT)));
        tmo_last = (tmo_cnt == TW'(TIMEOUT - 1));
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_IM;
            starve_cnt     <= '0;
            tmo_cnt        <= '0;
            Instruction    <= '0;
            IM_ready       <= 1'b0;
            DM_Read_Data   <= '0;
            DM_ready       <= 1'b0;
            MEM_Address    <= '0;
            MEM_req        <= 1'b0;
            MEM_we         <= 1'b0;
            MEM_Write_Data <= '0;
            bus_err        <= 1'b0;
        end else begin
            IM_ready <= 1'b0;
            DM_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (IM_req || DM_req) begin
                        if (grant_dm) begin
                            owner          <= OWN_DM;
                            MEM_Address    <= DM_Address;
                            MEM_we         <= DM_enable;
                            MEM_Write_Data <= DM_Write_Data;
                            if (IM_req && (starve_cnt != SW'(STARVE_LIMIT)))
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            owner          <= OWN_IM;
                            MEM_Address    <= IM_Address;
                            MEM_we         <= 1'b0;
                            MEM_Write_Data <= '0;
                            starve_cnt     <= '0;
                        end
                        MEM_req <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (MEM_ack || tmo_last) begin
                        // A timed-out access completes normally but delivers zero data.
                        if (!MEM_ack)
                            bus_err <= 1'b1;
                        if (owner == OWN_IM) begin
                            Instruction <= MEM_ack ? MEM_Read_Data : '0;
                            IM_ready    <= 1'b1;
                        end else begin
                            if (!MEM_we)
                                DM_Read_Data <= MEM_ack ? MEM_Read_Data : '0;
                            DM_ready <= 1'b1;
                        end
                        MEM_req <= 1'b0;
                        MEM_we  <= 1'b0;
                        state   <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
